// File: rtl/babbage_diff_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | babbage_diff_engine_if : load/start/step bus of the difference engine    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface babbage_diff_engine_if #(
   parameter int W  = 18,
   parameter int NW = 6
);
   logic          iLOAD;
   logic [2:0]    iSEL;
   logic [W-1:0]  iDATA;
   logic          iSTART;
   logic [NW-1:0] iN;
   logic          iABORT;
   logic          oREADY;
   logic          oDONE;
   logic          oSTEP_VALID;
   logic [W-1:0]  oF;
   logic          oOVF;

   modport master (
      output iLOAD, iSEL, iDATA, iSTART, iN, iABORT,
      input  oREADY, oDONE, oSTEP_VALID, oF, oOVF
   );

   modport slave (
      input  iLOAD, iSEL, iDATA, iSTART, iN, iABORT,
      output oREADY, oDONE, oSTEP_VALID, oF, oOVF
   );
endinterface
`default_nettype wire

// File: rtl/babbage_diff_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | babbage_diff_engine : finite-difference polynomial evaluator, degree DEG |
// | Optional macro BABBAGE_SIGNED_EN selects two's-complement overflow.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module babbage_diff_engine #(
   parameter int W   = 18,
   parameter int NW  = 6,
   parameter int DEG = 3
) (
   input  wire logic             iCLK,
   input  wire logic             iRESET_N,
   babbage_diff_engine_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_c [DEG+1];
   logic [W-1:0]  r_d [DEG+1];
   logic [W-1:0]  w_sum [DEG];
   logic [DEG-1:0] w_ovf_k;
   logic [NW-1:0] r_n;
   logic          r_ovf;
   logic          r_step_valid;
   logic          w_start;
   logic          w_step;

   // One adder per cascade stage, each fed by pre-edge register values.
   generate
      for (genvar k = 0; k < DEG; k++) begin : g_add
`ifdef BABBAGE_SIGNED_EN
         assign w_sum[k]   = r_d[k] + r_d[k+1];
         assign w_ovf_k[k] = (r_d[k][W-1] == r_d[k+1][W-1]) &&
                             (w_sum[k][W-1] != r_d[k][W-1]);
`else
         logic [W:0] w_full;
         assign w_full     = {1'b0, r_d[k]} + {1'b0, r_d[k+1]};
         assign w_sum[k]   = w_full[W-1:0];
         assign w_ovf_k[k] = w_full[W];
`endif
      end
   endgenerate

   always_ff @(posedge iCLK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = S_IDLE;
      w_start = 1'b0;
      w_step  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.iSTART) begin
               w_start = 1'b1;
               w_next  = S_CALC;
            end else begin
               w_next  = S_IDLE;
            end
         end
         S_CALC: begin
            if (bus.iABORT) begin
               w_next = S_IDLE;
            end else if (r_n == '0) begin
               w_next = S_DONE;
            end else begin
               w_step = 1'b1;
               w_next = S_CALC;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Start takes priority over a same-cycle load, so d copies the old c.
   always_ff @(posedge iCLK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         for (int k = 0; k <= DEG; k++) begin
            r_c[k] <= '0;
            r_d[k] <= '0;
         end
         r_n          <= '0;
         r_ovf        <= 1'b0;
         r_step_valid <= 1'b0;
      end else begin
         r_step_valid <= w_step;
         if (w_start) begin
            for (int k = 0; k <= DEG; k++) begin
               r_d[k] <= r_c[k];
            end
            r_n   <= bus.iN;
            r_ovf <= 1'b0;
         end else if ((r_state == S_IDLE) && bus.iLOAD) begin
            for (int k = 0; k <= DEG; k++) begin
               if (bus.iSEL == 3'(k)) begin
                  r_c[k] <= bus.iDATA;
               end
            end
         end
         if (w_step) begin
            for (int k = 0; k < DEG; k++) begin
               r_d[k] <= w_sum[k];
            end
            r_n <= r_n - 1'b1;
            if (|w_ovf_k) begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

   assign bus.oREADY      = (r_state == S_IDLE);
   assign bus.oDONE       = (r_state == S_DONE);
   assign bus.oSTEP_VALID = r_step_valid;
   assign bus.oF          = r_d[0];
   assign bus.oOVF        = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_babbage_diff_engine.sv
`default_nettype none
// Scoreboard bench for babbage_diff_engine: directed runs push expected
// step values and completion results; a negedge monitor pops and compares.
module tb_babbage_diff_engine;
`ifdef BABBAGE_SIGNED_EN
   localparam int W = 8;
`else
   localparam int W = 18;
`endif
   localparam int NW = 6;

   typedef struct {
      logic [W-1:0] f;
      logic         ovf;
   } done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [W-1:0] q_step [$];
   done_t        q_done [$];

   babbage_diff_engine_if #(.W(W), .NW(NW)) bus ();

   babbage_diff_engine #(.W(W), .NW(NW), .DEG(3)) dut (
      .iCLK     (clk),
      .iRESET_N (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every step pulse and done pulse must match the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.oSTEP_VALID) begin
         check("step_expected", 32'(q_step.size() != 0), 32'd1);
         if (q_step.size() != 0) check("step_value", 32'(bus.oF), 32'(q_step.pop_front()));
      end
      if (rst_n && bus.oDONE) begin
         check("done_expected", 32'(q_done.size() != 0), 32'd1);
         if (q_done.size() != 0) begin
            done_t e;
            e = q_done.pop_front();
            check("done_f", 32'(bus.oF), 32'(e.f));
            check("done_ovf", 32'(bus.oOVF), 32'(e.ovf));
         end
      end
   end

   task automatic load(input logic [2:0] sel, input logic [W-1:0] data);
      @(negedge clk);
      bus.iLOAD = 1'b1; bus.iSEL = sel; bus.iDATA = data;
      @(negedge clk);
      bus.iLOAD = 1'b0;
   endtask

   task automatic start_run(input logic [NW-1:0] n);
      @(negedge clk);
      bus.iSTART = 1'b1; bus.iN = n;
      @(negedge clk);
      bus.iSTART = 1'b0;
   endtask

   // Called in the cycle after the start edge; oDONE must rise after edge n+1.
   task automatic wait_done(input int n);
      int cnt = 0;
      while (!bus.oDONE && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("done_latency", 32'(cnt), 32'(n + 1));
   endtask

   task automatic push_done(input logic [W-1:0] f, input logic ovf);
      done_t e;
      e.f = f; e.ovf = ovf;
      q_done.push_back(e);
   endtask

   initial begin
      bus.iLOAD = 0; bus.iSEL = 0; bus.iDATA = 0; bus.iSTART = 0; bus.iN = 0; bus.iABORT = 0;
      repeat (2) @(negedge clk);
      check("rst_oF", 32'(bus.oF), 0);
      check("rst_ready", 32'(bus.oREADY), 1);
      check("rst_done", 32'(bus.oDONE), 0);
      check("rst_step", 32'(bus.oSTEP_VALID), 0);
      check("rst_ovf", 32'(bus.oOVF), 0);
      rst_n = 1'b1;

`ifdef BABBAGE_SIGNED_EN
      load(0, 8'hFD); load(1, 8'd2);
      q_step.push_back(8'hFF); q_step.push_back(8'd1);
      q_step.push_back(8'd3);  q_step.push_back(8'd5);
      push_done(8'd5, 1'b0);
      start_run(4); wait_done(4);
      load(0, 8'd100); load(1, 8'd30);
      q_step.push_back(8'h82);
      push_done(8'h82, 1'b1);
      start_run(1); wait_done(1);
`else
      // Cube table f(n) = (n+1)^3.
      load(0, 1); load(1, 7); load(2, 12); load(3, 6);
      q_step.push_back(8); q_step.push_back(27); q_step.push_back(64);
      q_step.push_back(125); q_step.push_back(216);
      push_done(216, 1'b0);
      start_run(5); wait_done(5);
      check("ready_after_done", 32'(bus.oREADY), 0);
      @(negedge clk);
      check("ready_idle", 32'(bus.oREADY), 1);
      check("hold_f", 32'(bus.oF), 216);

      for (int k = 1; k <= 62; k++) q_step.push_back(W'((k + 1) * (k + 1) * (k + 1)));
      push_done(W'(250047), 1'b0);
      start_run(62); wait_done(62);
      for (int k = 1; k <= 63; k++) q_step.push_back(W'((k + 1) * (k + 1) * (k + 1)));
      push_done(0, 1'b1);
      start_run(63); wait_done(63);

      push_done(1, 1'b0);
      start_run(0); wait_done(0);
      @(negedge clk);
      bus.iSTART = 1'b1; bus.iN = 1; bus.iLOAD = 1'b1; bus.iSEL = 0; bus.iDATA = 9;
      q_step.push_back(8);
      push_done(8, 1'b0);
      @(negedge clk);
      bus.iSTART = 1'b0; bus.iLOAD = 1'b0;
      wait_done(1);
      push_done(1, 1'b0);
      start_run(0); wait_done(0);

      // Abort after three steps, with a load attempted mid-run.
      q_step.push_back(8); q_step.push_back(27); q_step.push_back(64);
      start_run(5);
      @(negedge clk);
      bus.iLOAD = 1'b1; bus.iSEL = 0; bus.iDATA = 99;
      @(negedge clk);
      bus.iLOAD = 1'b0;
      @(negedge clk);
      bus.iABORT = 1'b1;
      @(negedge clk);
      bus.iABORT = 1'b0;
      check("abort_ready", 32'(bus.oREADY), 1);
      check("abort_f", 32'(bus.oF), 64);
      repeat (5) @(negedge clk);
      check("abort_steps_left", 32'(q_step.size()), 0);
      push_done(1, 1'b0);
      start_run(0); wait_done(0);

      // Asynchronous reset mid-run clears everything without a clock edge.
      q_step.push_back(8); q_step.push_back(27);
      start_run(5);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_oF", 32'(bus.oF), 0);
      check("arst_ready", 32'(bus.oREADY), 1);
      check("arst_step", 32'(bus.oSTEP_VALID), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) q_step.push_back(0);
      push_done(0, 1'b0);
      start_run(4); wait_done(4);
`endif
      repeat (3) @(negedge clk);
      check("step_queue_empty", 32'(q_step.size()), 0);
      check("done_queue_empty", 32'(q_done.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/babbage_diff_engine.md
Name: babbage_diff_engine

Overview:
Parametrised finite-difference polynomial evaluator, the successor to the fixed cubic engine.
- Difference coefficients for any polynomial up to degree DEG are loaded through a small write port and retained across runs.
- Each run evaluates f(N) by N rounds of cascaded additions, streams every intermediate f(k), and flags arithmetic overflow.
- Sits beside the datapath as a start/ready/done coprocessor.

Parameters:
W, 18, datapath width of every difference register and oF
NW, 6, width of iN and the step counter
DEG, 3, polynomial degree; number of difference registers is DEG+1; legal range 1..7

Ports:
iCLK  in  1  clock, rising edge
iRESET_N  in  1  asynchronous active-low reset
iLOAD  in  1  write strobe for coefficient register iSEL, honoured only in idle
iSEL  in  3  coefficient index 0..DEG; writes with iSEL>DEG are ignored
iDATA  in  W  coefficient value
iSTART  in  1  start request, sampled in idle
iN  in  NW  number of steps to evaluate
iABORT  in  1  abandon the current run
oREADY  out  1  high in idle
oDONE  out  1  one-cycle completion pulse
oSTEP_VALID  out  1  one-cycle pulse; oF holds a newly computed f(k)
oF  out  W  current value of difference register d0
oOVF  out  1  sticky overflow flag for the current or last run

Behaviour:
- Storage: coefficient regs c[0..DEG], working regs d[0..DEG], step counter n. c[0]=f(0) and c[k]=k-th forward difference at 0.
- Reset (asynchronous, iRESET_N low):
  - all c, d, n = 0; state = idle.
  - oF=0, oDONE=0, oSTEP_VALID=0, oOVF=0, oREADY=1.
  - Reset mid-run discards the run; no oDONE is produced.
- FSM states idle, calc, done; any illegal encoding goes to idle.
- idle:
  - oREADY=1.
  - iLOAD writes c[iSEL] <= iDATA.
  - iSTART: d[k] <= c[k] for all k, n <= iN, oOVF <= 0, next state calc.
  - iSTART and iLOAD in the same cycle: start wins, the load is dropped, and d takes the pre-existing c values.
- calc:
  - If iABORT=1, go to idle next edge. No oDONE; d and oF hold their partial values.
  - Else if n==0, go to done.
  - Else one step on this edge: d[k] <= d[k]+d[k+1] for k=0..DEG-1, all using pre-edge values; d[DEG] is unchanged; n <= n-1; oSTEP_VALID=1 in the following cycle.
  - iLOAD and iSTART are ignored in calc.
- done:
  - oDONE=1 for exactly one cycle, then idle.
  - iABORT has no effect in done.
- Latency: with iSTART sampled at edge 0, steps occur at edges 1..N and oDONE is high in the cycle after edge N+1. With iN=0, oDONE follows edge 1 and there are no oSTEP_VALID pulses.
- Output hold: oF = d0 at all times; the final f(N) holds until the next accepted iSTART. oSTEP_VALID is registered and pulses exactly N times per unaborted run.
- Arithmetic: modulo 2^W wraparound. Any step addition whose carry-out of bit W-1 is 1 sets oOVF on the same edge; oOVF stays set until the next accepted start.
- The c registers are never altered by a run.

Optional Feature:
BABBAGE_SIGNED_EN
- Defined: d, c and oF are two's-complement. oOVF sets when both operands of any step addition share a sign and the sum's sign differs.
- Undefined: unsigned arithmetic with overflow detected as carry-out, as above.
- Sequencing and latency are identical in both builds.

Test Plan:
1. Defaults; load c={1,7,12,6} for f(n)=(n+1)^3; iN=5 -> oSTEP_VALID shows oF sequence 8,27,64,125,216; oDONE in cycle after edge 6; oF=216; oOVF=0.
2. Same coefficients, iN=62 then iN=63.
   - iN=62 -> oF=250047, oOVF=0.
   - iN=63 -> oF wraps to 0 with oOVF=1, unsigned build.
3. iN=0 -> no oSTEP_VALID pulses, oDONE after edge 1, oF=1. Then iLOAD iSEL=0 iDATA=9 in the same cycle as iSTART -> load dropped, c0 still 1 on the next run.
4. iABORT asserted after 3 steps of test 1 -> idle next edge, oF=64, no oDONE. iLOAD during calc has no effect on c.
5. iRESET_N pulsed low mid-run -> oF=0, oREADY=1, all c cleared immediately without a clock; a subsequent start with iN=4 gives oF=0.
6. BABBAGE_SIGNED_EN, W=8, c={-3,2,0,0}, iN=4 -> oF steps -1,1,3,5, oOVF=0. c={100,30,0,0}, iN=1 -> oF=-126, oOVF=1.
